// File: rtl/sram_arbiter.sv
// Two-client SRAM port arbiter: display reads (fixed priority) and loader reads/writes.
// Optional loader starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int READ_LAT = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              C0_req,
  input  logic [ADDR_W-1:0] C0_addr,
  output logic              C0_gnt,
  output logic              C0_rdata_valid,
  output logic [15:0]       C0_rdata,
  input  logic              C1_req,
  input  logic              C1_we,
  input  logic [ADDR_W-1:0] C1_addr,
  input  logic [15:0]       C1_wdata,
  output logic              C1_gnt,
  output logic              C1_rdata_valid,
  output logic [15:0]       C1_rdata,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [15:0]       SRAM_write_data,
  output logic              SRAM_we_n,
  input  logic [15:0]       SRAM_read_data
);

  typedef enum logic {
    CLIENT_DISP = 1'b0,
    CLIENT_LOAD = 1'b1
  } client_e;

  typedef struct packed {
    logic    valid;
    client_e id;
  } trk_t;

  if (MAX_WAIT < 1) begin : g_bad_cfg
    $error("sram_arbiter: MAX_WAIT must be at least 1");
  end

  logic w_force_c1;
  logic w_c0_gnt;
  logic w_c1_gnt;
  trk_t r_trk [0:READ_LAT];

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge Clock_50) begin
    if (Reset || !C1_req || w_c1_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != CNT_W'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_force_c1 = (r_wait_cnt == CNT_W'(MAX_WAIT));
`else
  assign w_force_c1 = 1'b0;
`endif

  // Grants are pure combinational decode; Reset masks them so nothing issues during reset.
  assign w_c0_gnt = !Reset && C0_req && !(C1_req && w_force_c1);
  assign w_c1_gnt = !Reset && C1_req && (!C0_req || w_force_c1);

  assign C0_gnt = w_c0_gnt;
  assign C1_gnt = w_c1_gnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
    end else if (w_c1_gnt) begin
      SRAM_address    <= C1_addr;
      SRAM_write_data <= C1_wdata;
      SRAM_we_n       <= !C1_we;
    end else if (w_c0_gnt) begin
      SRAM_address    <= C0_addr;
      SRAM_we_n       <= 1'b1;
    end else begin
      SRAM_we_n       <= 1'b1;
    end
  end

  // NOTE: the tracker is reset in full (unlike a data RAM) so reads in flight at reset are dropped.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      for (int i = 0; i <= READ_LAT; i++) begin
        r_trk[i] <= '{valid: 1'b0, id: CLIENT_DISP};
      end
    end else begin
      r_trk[0].valid <= (w_c0_gnt) || (w_c1_gnt && !C1_we);
      r_trk[0].id    <= w_c1_gnt ? CLIENT_LOAD : CLIENT_DISP;
      for (int i = 1; i <= READ_LAT; i++) begin
        r_trk[i] <= r_trk[i-1];
      end
    end
  end

  assign C0_rdata_valid = !Reset && r_trk[READ_LAT].valid && (r_trk[READ_LAT].id == CLIENT_DISP);
  assign C1_rdata_valid = !Reset && r_trk[READ_LAT].valid && (r_trk[READ_LAT].id == CLIENT_LOAD);

  assign C0_rdata = SRAM_read_data;
  assign C1_rdata = SRAM_read_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a READ_LAT=2 SRAM emulator.
// Starvation expectations follow SRAM_ARB_STARVE_GUARD_EN.
module tb_sram_arbiter;

  localparam int ADDR_W = 18;

  logic              clk;
  logic              rst;
  logic              c0_req;
  logic [ADDR_W-1:0] c0_addr;
  logic              c0_gnt;
  logic              c0_rvalid;
  logic [15:0]       c0_rdata;
  logic              c1_req;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [15:0]       c1_wdata;
  logic              c1_gnt;
  logic              c1_rvalid;
  logic [15:0]       c1_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic              sram_we_n;
  logic [15:0]       sram_rdata;

  int n_pass  = 0;
  int n_total = 0;

  sram_arbiter #(.ADDR_W(ADDR_W), .READ_LAT(2), .MAX_WAIT(8)) dut (
    .Clock_50       (clk),
    .Reset          (rst),
    .C0_req         (c0_req),
    .C0_addr        (c0_addr),
    .C0_gnt         (c0_gnt),
    .C0_rdata_valid (c0_rvalid),
    .C0_rdata       (c0_rdata),
    .C1_req         (c1_req),
    .C1_we          (c1_we),
    .C1_addr        (c1_addr),
    .C1_wdata       (c1_wdata),
    .C1_gnt         (c1_gnt),
    .C1_rdata_valid (c1_rvalid),
    .C1_rdata       (c1_rdata),
    .SRAM_address   (sram_addr),
    .SRAM_write_data(sram_wdata),
    .SRAM_we_n      (sram_we_n),
    .SRAM_read_data (sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // SRAM emulator: address on pins in cycle k yields data in cycle k+2.
  logic [15:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] p1, p2;
  always @(posedge clk) begin
    if (sram_we_n == 1'b0) mem[sram_addr] <= sram_wdata;
    p1 <= sram_addr;
    p2 <= p1;
  end
  assign sram_rdata = mem[p2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; c0_req = 1'b1; c1_req = 1'b1; c1_we = 1'b1;
    c0_addr = 18'h00ABC; c1_addr = 18'h00DEF; c1_wdata = 16'hBEEF;
    step(); #2;
    n_total++;
    if (c0_gnt !== 1'b0 || c1_gnt !== 1'b0)
      $display("FAIL reset_gnt_c1: got c0=%b c1=%b want 0 0", c0_gnt, c1_gnt);
    else n_pass++;
    step(); #2;
    n_total++;
    if (c0_gnt !== 1'b0 || c1_gnt !== 1'b0)
      $display("FAIL reset_gnt_c2: got c0=%b c1=%b want 0 0", c0_gnt, c1_gnt);
    else n_pass++;
    n_total++;
    if (sram_we_n !== 1'b1) $display("FAIL reset_we_n: got %b want 1", sram_we_n);
    else n_pass++;
    n_total++;
    if (sram_addr !== 18'h0) $display("FAIL reset_addr: got %h want 00000", sram_addr);
    else n_pass++;
    n_total++;
    if (sram_wdata !== 16'h0) $display("FAIL reset_wdata: got %h want 0000", sram_wdata);
    else n_pass++;
    n_total++;
    if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0)
      $display("FAIL reset_rvalid: got c0=%b c1=%b want 0 0", c0_rvalid, c1_rvalid);
    else n_pass++;
  endtask

  task automatic test_single_read();
    step();
    rst = 1'b0; c0_req = 1'b1; c0_addr = 18'h00100; c1_req = 1'b0; #2;
    n_total++;
    if (c0_gnt !== 1'b1 || c1_gnt !== 1'b0)
      $display("FAIL single_gnt: got c0=%b c1=%b want 1 0", c0_gnt, c1_gnt);
    else n_pass++;
    step();
    c0_req = 1'b0; #2;
    n_total++;
    if (sram_addr !== 18'h00100 || sram_we_n !== 1'b1)
      $display("FAIL single_pins: got addr=%h we_n=%b want 00100 1", sram_addr, sram_we_n);
    else n_pass++;
    step(); #2;
    n_total++;
    if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0)
      $display("FAIL single_early: got c0=%b c1=%b want 0 0", c0_rvalid, c1_rvalid);
    else n_pass++;
    step(); #2;
    n_total++;
    if (c0_rvalid !== 1'b1 || c1_rvalid !== 1'b0)
      $display("FAIL single_valid: got c0=%b c1=%b want 1 0", c0_rvalid, c1_rvalid);
    else n_pass++;
    n_total++;
    if (c0_rdata !== 16'hA5C3) $display("FAIL single_data: got %h want a5c3", c0_rdata);
    else n_pass++;
    step(); #2;
    n_total++;
    if (c0_rvalid !== 1'b0) $display("FAIL single_after: got %b want 0", c0_rvalid);
    else n_pass++;
  endtask

  task automatic test_contention();
    for (int i = 0; i < 6; i++) begin
      step();
      c0_req = (i % 2 == 0); c0_addr = 18'h00100;
      c1_req = 1'b1; c1_we = 1'b1; c1_addr = 18'h3FFFF; c1_wdata = 16'h1234; #2;
      n_total++;
      if (c0_gnt !== (i % 2 == 0) || c1_gnt !== (i % 2 == 1))
        $display("FAIL cont_gnt[%0d]: got c0=%b c1=%b want %b %b", i, c0_gnt, c1_gnt,
                 (i % 2 == 0), (i % 2 == 1));
      else n_pass++;
      n_total++;
      if (c0_rvalid !== (i == 3 || i == 5) || c1_rvalid !== 1'b0)
        $display("FAIL cont_rvalid[%0d]: got c0=%b c1=%b want %b 0", i, c0_rvalid, c1_rvalid,
                 (i == 3 || i == 5));
      else n_pass++;
      if (i >= 1) begin
        n_total++;
        if (sram_we_n !== ((i - 1) % 2 == 0))
          $display("FAIL cont_we_n[%0d]: got %b want %b", i, sram_we_n, ((i - 1) % 2 == 0));
        else n_pass++;
      end
    end
    step();
    c0_req = 1'b0; c1_we = 1'b0; #2;
    n_total++;
    if (c1_gnt !== 1'b1 || c0_gnt !== 1'b0)
      $display("FAIL raw_gnt: got c0=%b c1=%b want 0 1", c0_gnt, c1_gnt);
    else n_pass++;
    n_total++;
    if (sram_we_n !== 1'b0 || sram_addr !== 18'h3FFFF || sram_wdata !== 16'h1234)
      $display("FAIL raw_write_pins: got we_n=%b addr=%h data=%h want 0 3ffff 1234",
               sram_we_n, sram_addr, sram_wdata);
    else n_pass++;
    step();
    c1_req = 1'b0; #2;
    n_total++;
    if (sram_we_n !== 1'b1 || sram_addr !== 18'h3FFFF)
      $display("FAIL raw_read_pins: got we_n=%b addr=%h want 1 3ffff", sram_we_n, sram_addr);
    else n_pass++;
    n_total++;
    if (c0_rvalid !== 1'b1 || c1_rvalid !== 1'b0)
      $display("FAIL cont_last_c0: got c0=%b c1=%b want 1 0", c0_rvalid, c1_rvalid);
    else n_pass++;
    step(); #2;
    n_total++;
    if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0)
      $display("FAIL raw_early: got c0=%b c1=%b want 0 0", c0_rvalid, c1_rvalid);
    else n_pass++;
    step(); #2;
    n_total++;
    if (c1_rvalid !== 1'b1 || c0_rvalid !== 1'b0 || c1_rdata !== 16'h1234)
      $display("FAIL raw_data: got c1v=%b c0v=%b data=%h want 1 0 1234", c1_rvalid, c0_rvalid,
               c1_rdata);
    else n_pass++;
  endtask

  task automatic test_starvation();
`ifdef SRAM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 20; i++) begin
      step();
      c0_req = 1'b1; c0_addr = 18'h00100;
      c1_req = 1'b1; c1_we = 1'b0; c1_addr = 18'h00200; #2;
      n_total++;
      if (c1_gnt !== (i == 8 || i == 17) || c0_gnt !== !(i == 8 || i == 17))
        $display("FAIL starve_guard[%0d]: got c0=%b c1=%b want %b %b", i, c0_gnt, c1_gnt,
                 !(i == 8 || i == 17), (i == 8 || i == 17));
      else n_pass++;
    end
`else
    int bad_c1 = 0;
    int bad_c0 = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      c0_req = 1'b1; c0_addr = 18'h00100;
      c1_req = 1'b1; c1_we = 1'b0; c1_addr = 18'h00200; #2;
      if (c1_gnt !== 1'b0) bad_c1++;
      if (c0_gnt !== 1'b1) bad_c0++;
    end
    n_total++;
    if (bad_c1 != 0) $display("FAIL starve_c1_gnt: got %0d grants want 0", bad_c1);
    else n_pass++;
    n_total++;
    if (bad_c0 != 0) $display("FAIL starve_c0_gnt: got %0d denials want 0", bad_c0);
    else n_pass++;
`endif
    step();
    c0_req = 1'b0; c1_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset_mid_read();
    step();
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 18'h00100; #2;
    n_total++;
    if (c1_gnt !== 1'b1) $display("FAIL midrst_gnt: got %b want 1", c1_gnt);
    else n_pass++;
    step();
    rst = 1'b1; c0_req = 1'b1; #2;
    n_total++;
    if (c0_gnt !== 1'b0 || c1_gnt !== 1'b0)
      $display("FAIL midrst_gnt_mask: got c0=%b c1=%b want 0 0", c0_gnt, c1_gnt);
    else n_pass++;
    step();
    rst = 1'b0; c0_req = 1'b0; c1_req = 1'b0; #2;
    n_total++;
    if (sram_addr !== 18'h0 || sram_we_n !== 1'b1)
      $display("FAIL midrst_pins: got addr=%h we_n=%b want 00000 1", sram_addr, sram_we_n);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step(); #2;
      n_total++;
      if (c1_rvalid !== 1'b0 || c0_rvalid !== 1'b0)
        $display("FAIL midrst_drop[%0d]: got c1=%b c0=%b want 0 0", i, c1_rvalid, c0_rvalid);
      else n_pass++;
    end
  endtask

  initial begin
    mem[18'h00100] = 16'hA5C3;
    test_reset();
    test_single_read();
    test_contention();
    test_starvation();
    test_reset_mid_read();
    test_single_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
